bit_count_seq: RTL and testbench

Parametrised sequential bit-statistics engine: captures a DATA_W-bit operand on a start request and counts ones, zeros, leading zeros or trailing zeros by shifting one bit per clock. It is the generalised successor of the fixed 8-bit ones counter, organised as the same controller/datapath split. The ones and zeros modes terminate early once the remaining operand is zero. It sits behind any block that needs population or zero-run counts and can tolerate multi-cycle latency.

---
 rtl/bit_count_pkg.sv | 24 ++
 rtl/bit_count_seq_if.sv | 33 +++
 rtl/bit_count_ctrl.sv | 105 ++++++++++
 rtl/bit_count_seq.sv | 92 +++++++++
 tb/tb_bit_count_seq.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_count_pkg.sv
// Shared types and helpers for the sequential bit-statistics engine.
package bit_count_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation selected by the mode input, captured with start.
  typedef enum logic [1:0] {
    M_ONES  = 2'd0,
    M_ZEROS = 2'd1,
    M_LZC   = 2'd2,
    M_TZC   = 2'd3
  } mode_t;

  // Width of a counter that can hold values 0..data_w inclusive.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/bit_count_seq_if.sv
// Request/result bundle of bit_count_seq.
//
// Handshake: the master raises start with mode/data valid. The request is
// taken only on a rising edge where rdy is high (IDLE). rdy drops for
// the whole operation. done pulses high for exactly one cycle when count
// holds the final result. count stays valid while rdy is high afterwards.
// dbg_state mirrors the controller state for observation only.
interface bit_count_seq_if
  import bit_count_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = cnt_width(DATA_W)
);

  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] data;
  logic [CNT_W-1:0]  count;
  logic              rdy;
  logic              done;
  state_t            dbg_state;

  modport master (
    output start, mode, data,
    input  count, rdy, done, dbg_state
  );

  modport slave (
    input  start, mode, data,
    output count, rdy, done, dbg_state
  );

endinterface

// File: rtl/bit_count_ctrl.sv
// Controller for bit_count_seq: owns the state register, decides when the
// count is finished from the datapath status flags, and issues the
// datapath strobes. rdy/done are registered alongside the state so they
// depend on the state register only.
module bit_count_ctrl
  import bit_count_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start_i,
  input  mode_t  mode_i,
  input  logic   r1_zero_i,
  input  logic   r1_msb_i,
  input  logic   r1_lsb_i,
  input  logic   left_zero_i,
  output logic   load_o,
  output logic   shift_l_o,
  output logic   shift_r_o,
  output logic   incr_o,
  output logic   rdy_o,
  output logic   done_o,
  output state_t state_o
);

  state_t state_q;
  logic   rdy_q;
  logic   done_q;
  logic   fin;

  // Termination test for the captured mode, evaluated on the current R1.
  always_comb begin
    fin = 1'b0;
    case (mode_i)
      M_ONES, M_ZEROS: fin = r1_zero_i;
      M_LZC:           fin = r1_msb_i | left_zero_i;
      M_TZC:           fin = r1_lsb_i | left_zero_i;
      default:         fin = 1'b1;
    endcase
  end

  // Datapath strobes: load on an accepted request, one shift per COUNT cycle.
  always_comb begin
    load_o    = 1'b0;
    shift_l_o = 1'b0;
    shift_r_o = 1'b0;
    incr_o    = 1'b0;
    if (state_q == IDLE) begin
      load_o = start_i;
    end else if (state_q == COUNT && !fin) begin
      case (mode_i)
        M_ONES, M_ZEROS: begin
          shift_r_o = 1'b1;
          incr_o    = r1_lsb_i;
        end
        M_LZC: begin
          shift_l_o = 1'b1;
          incr_o    = 1'b1;
        end
        default: begin
          shift_r_o = 1'b1;
          incr_o    = 1'b1;
        end
      endcase
    end
  end

  // State register with rdy/done registered to match the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= COUNT;
            rdy_q   <= 1'b0;
          end
        end
        COUNT: begin
          if (fin) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rdy_o   = rdy_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: rtl/bit_count_seq.sv
// Sequential bit-statistics engine: counts ones, zeros, leading zeros or
// trailing zeros of a captured operand by shifting one bit per clock.
// Holds the datapath (R1 operand, R2 count, bits_left, mode_r) and the
// controller instance.
module bit_count_seq
  import bit_count_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input logic            clk,
  input logic            rst,
  bit_count_seq_if.slave bus
);

  logic [DATA_W-1:0] r1_q, r1_d;
  logic [CNT_W-1:0]  r2_q, r2_d;
  logic [CNT_W-1:0]  left_q, left_d;
  mode_t             mode_q, mode_d;

  logic load, shift_l, shift_r, incr;
  logic rdy, done;
  mode_t mode_in;

  assign mode_in = mode_t'(bus.mode);

  // Next-state datapath: capture on load, otherwise shift/increment.
  // Zeros mode counts ones of the inverted operand, so it shares the
  // early-exit ones path. bits_left bounds the zero-run modes on an
  // all-zero operand.
  always_comb begin
    r1_d   = r1_q;
    r2_d   = r2_q;
    left_d = left_q;
    mode_d = mode_q;
    if (load) begin
      mode_d = mode_in;
      r1_d   = (mode_in == M_ZEROS) ? ~bus.data : bus.data;
      r2_d   = '0;
      left_d = CNT_W'(DATA_W);
    end else begin
      if (shift_r) begin
        r1_d   = r1_q >> 1;
        left_d = left_q - CNT_W'(1);
      end else if (shift_l) begin
        r1_d   = r1_q << 1;
        left_d = left_q - CNT_W'(1);
      end
      if (incr) begin
        r2_d = r2_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q   <= '0;
      r2_q   <= '0;
      left_q <= '0;
      mode_q <= M_ONES;
    end else begin
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      left_q <= left_d;
      mode_q <= mode_d;
    end
  end

  bit_count_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start_i     (bus.start),
    .mode_i      (mode_q),
    .r1_zero_i   (r1_q == '0),
    .r1_msb_i    (r1_q[DATA_W-1]),
    .r1_lsb_i    (r1_q[0]),
    .left_zero_i (left_q == '0),
    .load_o      (load),
    .shift_l_o   (shift_l),
    .shift_r_o   (shift_r),
    .incr_o      (incr),
    .rdy_o       (rdy),
    .done_o      (done),
    .state_o     (bus.dbg_state)
  );

  assign bus.count = r2_q;
  assign bus.rdy   = rdy;
  assign bus.done  = done;

endmodule

// File: tb/tb_bit_count_seq.sv
// Testbench for bit_count_seq: an 8-bit and a 16-bit instance driven by
// directed operations, checked every cycle against a timeline model.
module tb_bit_count_seq;
  import bit_count_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  bit_count_seq_if #(.DATA_W(8))  bus8  ();
  bit_count_seq_if #(.DATA_W(16)) bus16 ();

  bit_count_seq #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  bit_count_seq #(.DATA_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  logic        st[2];
  logic [1:0]  md[2];
  logic [15:0] dt[2];

  assign bus8.start  = st[0];
  assign bus8.mode   = md[0];
  assign bus8.data   = dt[0][7:0];
  assign bus16.start = st[1];
  assign bus16.mode  = md[1];
  assign bus16.data  = dt[1];

  logic [15:0] obs_cnt[2];
  logic        obs_rdy[2];
  logic        obs_done[2];
  state_t      obs_st[2];

  assign obs_cnt[0]  = 16'(bus8.count);
  assign obs_cnt[1]  = 16'(bus16.count);
  assign obs_rdy[0]  = bus8.rdy;
  assign obs_rdy[1]  = bus16.rdy;
  assign obs_done[0] = bus8.done;
  assign obs_done[1] = bus16.done;
  assign obs_st[0]   = dut8.u_ctrl.state_q;
  assign obs_st[1]   = dut16.u_ctrl.state_q;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, i, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Result straight from the definition of each statistic.
  function automatic int ref_count(input int w, input int m, input logic [15:0] d);
    int n = 0;
    case (m)
      0: for (int i = 0; i < w; i++) n += int'(d[i]);
      1: for (int i = 0; i < w; i++) n += int'(!d[i]);
      2: for (int i = w - 1; i >= 0; i--) begin
           if (d[i]) break;
           n++;
         end
      default: for (int i = 0; i < w; i++) begin
           if (d[i]) break;
           n++;
         end
    endcase
    return n;
  endfunction

  // Number of COUNT cycles: highest set bit of the counted pattern + 2
  // (1 for none) in ones/zeros modes, result + 1 in zero-run modes.
  function automatic int ref_len(input int w, input int m, input logic [15:0] d);
    int hi = -1;
    if (m >= 2) return ref_count(w, m, d) + 1;
    for (int i = 0; i < w; i++) begin
      if ((m == 0) ? d[i] : !d[i]) hi = i;
    end
    return (hi < 0) ? 1 : hi + 2;
  endfunction

  // Timeline model: 0 idle, 1 counting, 2 done.
  int ph[2];
  int rem[2];
  int pend[2];
  int held[2];
  int wid[2];
  initial begin
    wid[0] = 8;
    wid[1] = 16;
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; rem[i] = 0; pend[i] = 0; held[i] = 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i]   <= 0;
        rem[i]  <= 0;
        held[i] <= 0;
      end else begin
        case (ph[i])
          0: if (st[i]) begin
               ph[i]   <= 1;
               rem[i]  <= ref_len(wid[i], int'(md[i]), dt[i]);
               pend[i] <= ref_count(wid[i], int'(md[i]), dt[i]);
             end
          1: if (rem[i] == 1) begin
               ph[i]   <= 2;
               held[i] <= pend[i];
             end else begin
               rem[i] <= rem[i] - 1;
             end
          default: ph[i] <= 0;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("rdy", i, 32'(obs_rdy[i]), 32'(ph[i] == 0));
        check("done", i, 32'(obs_done[i]), 32'(ph[i] == 2));
        check("state", i, 32'(obs_st[i]),
              (ph[i] == 0) ? 32'(IDLE) : (ph[i] == 1) ? 32'(COUNT) : 32'(DONE));
        if (ph[i] != 1) check("count", i, 32'(obs_cnt[i]), 32'(held[i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at posedge+#1 with the DUT idle; returns aligned the same way.
  task automatic run_op(input int i, input int m, input logic [15:0] d,
                        input int exp_cnt, input int exp_len);
    int  k = 0;
    bit  seen = 1'b0;
    st[i] = 1'b1;
    md[i] = m[1:0];
    dt[i] = d;
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    md[i] = 2'($urandom_range(0, 3));
    dt[i] = 16'($urandom);
    while (k < 40 && !seen) begin
      @(negedge clk);
      k++;
      if (obs_done[i]) seen = 1'b1;
    end
    check("done_seen", i, 32'(seen), 32'd1);
    check("count_cycles", i, 32'(k - 1), 32'(exp_len));
    check("result", i, 32'(obs_cnt[i]), 32'(exp_cnt));
    @(negedge clk);
    check("rdy_after", i, 32'(obs_rdy[i]), 32'd1);
    check("result_held", i, 32'(obs_cnt[i]), 32'(exp_cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_count(input int i, input logic [15:0] d);
    st[i] = 1'b1;
    md[i] = 2'd0;
    dt[i] = d;
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", i, 32'(obs_st[i]), 32'(IDLE));
    check("rst_count", i, 32'(obs_cnt[i]), 32'd0);
    check("rst_rdy", i, 32'(obs_rdy[i]), 32'd1);
    check("rst_done", i, 32'(obs_done[i]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_done;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      md[i] = 2'd0;
      dt[i] = 16'd0;
    end

    // Model spot checks against hand-computed values.
    check("ref_pop_aa", 0, 32'(ref_count(8, 0, 16'h00AA)), 32'd4);
    check("ref_lzc_10", 0, 32'(ref_count(8, 2, 16'h0010)), 32'd3);
    check("ref_len_aa", 0, 32'(ref_len(8, 0, 16'h00AA)), 32'd9);
    check("ref_tzc_a0", 0, 32'(ref_count(8, 3, 16'h00A0)), 32'd5);

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_count", 0, 32'(obs_cnt[0]), 32'd0);
    check("reset_rdy", 0, 32'(obs_rdy[0]), 32'd1);
    check("reset_done", 0, 32'(obs_done[0]), 32'd0);
    check("reset_state", 1, 32'(obs_st[1]), 32'(IDLE));
    @(posedge clk);
    #1;

    // 8-bit directed operations: dut, mode, data, count, COUNT cycles.
    run_op(0, 0, 16'h00FF, 8, 9);
    run_op(0, 0, 16'h00AA, 4, 9);
    run_op(0, 0, 16'h0000, 0, 1);
    run_op(0, 1, 16'h00FF, 0, 1);
    run_op(0, 1, 16'h00F0, 4, 5);
    run_op(0, 2, 16'h0010, 3, 4);
    run_op(0, 2, 16'h0000, 8, 9);
    run_op(0, 3, 16'h00A0, 5, 6);
    run_op(0, 3, 16'h0001, 0, 1);
    run_op(0, 2, 16'h0080, 0, 1);

    // Reset mid-operation, then a fresh request.
    reset_mid_count(0, 16'h00FF);
    run_op(0, 0, 16'h00AA, 4, 9);

    // start held high: zero operand gives one operation every 3 cycles.
    st[0] = 1'b1;
    md[0] = 2'd0;
    dt[0] = 16'd0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_done[0]) n_done++;
    end
    st[0] = 1'b0;
    check("held_start_dones", 0, 32'(n_done), 32'd4);
    @(posedge clk);
    #1;

    // 16-bit instance.
    reset_mid_count(1, 16'h8001);
    run_op(1, 0, 16'h8001, 2, 17);
    run_op(1, 2, 16'h0000, 16, 17);
    run_op(1, 3, 16'h0100, 8, 9);
    run_op(1, 1, 16'h00FF, 8, 17);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
